// File: rtl/presc_pkg.sv
// Shared types and defaults for the multi-channel prescaler.
package presc_pkg;

    localparam int PRESC_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_PEND = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic                       en;
        logic [PRESC_CNT_W_DEF-1:0] div;
    } presc_cfg_t;

endpackage

// File: rtl/mod_presc_ch.sv
// One prescaler channel: IDLE/RUN/PEND FSM, terminal counter, pending divide register,
// registered tick strobe and 50%-duty divided clock.
module mod_presc_ch
    import presc_pkg::*;
#(
    parameter int               CNT_W   = PRESC_CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic             sync_i,
    input  logic             hold_i,
    output logic             tick_o,
    output logic             clk_o,
    output ch_state_e        state_o
);

    ch_state_e        state_q, state_d, wr_state;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CH_IDLE;
            div_q   <= DIV_RST;
            cnt_q   <= '0;
            pend_q  <= DIV_RST;
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        clk_d    = clk_q;
        wr_state = state_q;

        case (state_q)
            CH_RUN, CH_PEND: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    clk_d  = ~clk_q;
                    if (state_q == CH_PEND) begin
                        div_d   = pend_q;
                        state_d = CH_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        // Sync restarts a running channel first; a same-cycle write then sees it as RUN.
        if (sync_i && (state_q != CH_IDLE)) begin
            cnt_d    = '0;
            tick_d   = 1'b0;
            clk_d    = 1'b0;
            if (state_q == CH_PEND) begin
                div_d = pend_q;
            end
            state_d  = CH_RUN;
            wr_state = CH_RUN;
        end

        if (wr_i) begin
            if (!wr_en_i) begin
                state_d = CH_IDLE;
                div_d   = wr_div_i;
                cnt_d   = '0;
                tick_d  = 1'b0;
                clk_d   = 1'b0;
            end else if (wr_state == CH_IDLE) begin
                div_d   = wr_div_i;
                cnt_d   = '0;
                state_d = CH_RUN;
            end else begin
                pend_d  = wr_div_i;
                state_d = CH_PEND;
            end
        end

        if (hold_i) begin
            state_d = CH_IDLE;
            cnt_d   = '0;
            tick_d  = 1'b0;
            clk_d   = 1'b0;
        end
    end

    assign tick_o  = tick_q;
    assign clk_o   = clk_q;
    assign state_o = state_q;

endmodule

// File: rtl/mod_presc_multi.sv
// Multi-channel programmable prescaler: NUM_CH channels, shared config port and global sync.
// Optional power-on hold of cfg_ready_o is built when PRESC_MULTI_POR_EN is defined.
module mod_presc_multi
    import presc_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = PRESC_CNT_W_DEF,
    parameter int unsigned DIV_RST   = 0,
    parameter int          POR_TICKS = 1000,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    input  logic              cfg_en_i,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_o
);

    // Per-channel FSM state, kept as a named array so it can be observed directly.
    ch_state_e         ch_state [NUM_CH];
    logic [NUM_CH-1:0] ch_pend;
    logic              por_busy;
    logic              wr_acc;
    logic              sync_eff;

    assign wr_acc      = cfg_valid_i && cfg_ready_o;
    assign sync_eff    = sync_i && !por_busy;
    assign cfg_ready_o = !(|ch_pend) && !por_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mod_presc_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (CNT_W'(DIV_RST))
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wr_i     (wr_acc && (cfg_ch_i == CH_W'(g))),
            .wr_en_i  (cfg_en_i),
            .wr_div_i (cfg_div_i),
            .sync_i   (sync_eff),
            .hold_i   (por_busy),
            .tick_o   (tick_o[g]),
            .clk_o    (clk_o[g]),
            .state_o  (ch_state[g])
        );
        assign ch_pend[g] = (ch_state[g] == CH_PEND);
    end

`ifdef PRESC_MULTI_POR_EN
    localparam int POR_W = (POR_TICKS > 1) ? $clog2(POR_TICKS + 1) : 1;

    logic [POR_W-1:0] por_cnt_q, por_cnt_d;

    assign por_busy  = (por_cnt_q < POR_W'(POR_TICKS));
    assign por_cnt_d = por_busy ? (por_cnt_q + POR_W'(1)) : por_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            por_cnt_q <= '0;
        end else begin
            por_cnt_q <= por_cnt_d;
        end
    end
`else
    // No power-on hold; only a nonsensical negative hold length would block config.
    assign por_busy = (POR_TICKS < 0);
`endif

endmodule

// File: tb/tb_mod_presc_multi.sv
// Self-checking bench for mod_presc_multi: tick-time reference model plus directed literal checks.
module tb_mod_presc_multi;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;
`ifdef PRESC_MULTI_POR_EN
    localparam int MODEL_POR = 20;
`else
    localparam int MODEL_POR = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_en;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clko;

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference model: each running channel is described by the absolute cycle of its next tick.
    bit m_run  [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_clk  [NUM_CH];
    bit m_tick [NUM_CH];
    int m_div  [NUM_CH];
    int m_pdiv [NUM_CH];
    int m_next [NUM_CH];
    bit m_ready;
    int m_por;

    mod_presc_multi #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DIV_RST   (0),
        .POR_TICKS (20)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_ch_i    (cfg_ch),
        .cfg_div_i   (cfg_div),
        .cfg_en_i    (cfg_en),
        .sync_i      (sync),
        .tick_o      (tick),
        .clk_o       (clko)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_run[i]  = 0;
            m_pend[i] = 0;
            m_clk[i]  = 0;
            m_tick[i] = 0;
            m_div[i]  = 0;
            m_pdiv[i] = 0;
            m_next[i] = 0;
        end
        m_por   = MODEL_POR;
        m_ready = (MODEL_POR == 0);
    endtask

    task automatic model_step();
        bit acc;
        bit sy;
        bit any_pend;
        acc = cfg_valid && m_ready;
        sy  = sync && (m_por == 0);
        any_pend = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 0;
            if (m_run[i]) begin
                if (sy) begin
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 0;
                    end
                    m_next[i] = cyc + m_div[i] + 2;
                    m_clk[i]  = 0;
                end else if (m_next[i] == cyc + 1) begin
                    m_tick[i] = 1;
                    m_clk[i]  = !m_clk[i];
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 0;
                    end
                    m_next[i] = cyc + 1 + m_div[i] + 1;
                end
            end
            if (acc && (int'(cfg_ch) == i)) begin
                if (!cfg_en) begin
                    m_run[i]  = 0;
                    m_pend[i] = 0;
                    m_clk[i]  = 0;
                    m_tick[i] = 0;
                    m_div[i]  = int'(cfg_div);
                end else if (m_run[i]) begin
                    m_pend[i] = 1;
                    m_pdiv[i] = int'(cfg_div);
                end else begin
                    m_run[i]  = 1;
                    m_div[i]  = int'(cfg_div);
                    m_next[i] = cyc + m_div[i] + 2;
                    m_clk[i]  = 0;
                end
            end
            any_pend |= m_pend[i];
        end
        if (m_por > 0) m_por--;
        m_ready = (m_por == 0) && !any_pend;
    endtask

    // Compare process: outputs are checked mid-cycle, then the model advances on this cycle's inputs.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] et;
        logic [NUM_CH-1:0] ec;
        if (!rst_n) model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = m_tick[i];
            ec[i] = m_clk[i];
        end
        chk("model_tick", 32'(tick), 32'(et));
        chk("model_clk", 32'(clko), 32'(ec));
        chk("model_ready", 32'(cfg_ready), 32'(m_ready));
        if (rst_n) begin
            model_step();
            cyc++;
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int div, input bit en);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(div);
        cfg_en    = en;
        adv(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        adv(1);
        sync = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        model_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        sync      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk", 32'(clko), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'(MODEL_POR == 0));
        rst_n = 1'b1;

`ifdef PRESC_MULTI_POR_EN
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd3;
        cfg_en    = 1'b1;
        adv(19);
        chk("por_ready_low", 32'(cfg_ready), 32'd0);
        adv(1);
        chk("por_ready_high", 32'(cfg_ready), 32'd1);
        adv(1);
        cfg_valid = 1'b0;
        adv(4);
        chk("por_first_tick", 32'(tick[0]), 32'd1);
        wr(0, 0, 0);
`endif

        // ch0 D=3: ticks at T+5, T+9, T+13; clk_o period 8.
        wr(0, 3, 1);
        adv(3);
        chk("t1_tick_T4", 32'(tick[0]), 32'd0);
        adv(1);
        chk("t1_tick_T5", 32'(tick[0]), 32'd1);
        chk("t1_clk_T5", 32'(clko[0]), 32'd1);
        adv(3);
        chk("t1_clk_T8", 32'(clko[0]), 32'd1);
        chk("t1_tick_T8", 32'(tick[0]), 32'd0);
        adv(1);
        chk("t1_tick_T9", 32'(tick[0]), 32'd1);
        chk("t1_clk_T9", 32'(clko[0]), 32'd0);
        adv(4);
        chk("t1_tick_T13", 32'(tick[0]), 32'd1);
        chk("t1_clk_T13", 32'(clko[0]), 32'd1);

        // ch1 D=2 then D=5 mid-period: old period completes, then 6-cycle period.
        wr(1, 2, 1);
        adv(4);
        wr(1, 5, 1);
        chk("t2_ready_pend", 32'(cfg_ready), 32'd0);
        adv(1);
        chk("t2_tick_old", 32'(tick[1]), 32'd1);
        chk("t2_ready_back", 32'(cfg_ready), 32'd1);
        adv(5);
        chk("t2_tick_gap", 32'(tick[1]), 32'd0);
        adv(1);
        chk("t2_tick_new1", 32'(tick[1]), 32'd1);
        adv(6);
        chk("t2_tick_new2", 32'(tick[1]), 32'd1);

        // ch2 D=0: tick continuous, clk_o toggles each cycle; disable clears both next cycle.
        wr(2, 0, 1);
        adv(1);
        chk("t3_tick_a", 32'(tick[2]), 32'd1);
        chk("t3_clk_a", 32'(clko[2]), 32'd1);
        adv(1);
        chk("t3_tick_b", 32'(tick[2]), 32'd1);
        chk("t3_clk_b", 32'(clko[2]), 32'd0);
        adv(1);
        chk("t3_clk_c", 32'(clko[2]), 32'd1);
        wr(2, 0, 0);
        chk("t3_off_tick", 32'(tick[2]), 32'd0);
        chk("t3_off_clk", 32'(clko[2]), 32'd0);

        // Sync with ch0 D=3 and ch1 D=7 running.
        wr(0, 0, 0);
        wr(1, 0, 0);
        wr(0, 3, 1);
        wr(1, 7, 1);
        adv(3);
        do_sync();
        chk("t4_tick_S1", 32'(tick[1:0]), 32'd0);
        chk("t4_clk_S1", 32'(clko[1:0]), 32'd0);
        adv(3);
        chk("t4_ch0_S4", 32'(tick[0]), 32'd0);
        adv(1);
        chk("t4_ch0_S5", 32'(tick[0]), 32'd1);
        adv(3);
        chk("t4_ch1_S8", 32'(tick[1]), 32'd0);
        adv(1);
        chk("t4_ch1_S9", 32'(tick[1]), 32'd1);

        // Asynchronous reset between edges while ch2 ticks continuously.
        wr(2, 0, 1);
        adv(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_tick", 32'(tick), 32'd0);
        chk("t5_async_clk", 32'(clko), 32'd0);
        chk("t5_async_ready", 32'(cfg_ready), 32'(MODEL_POR == 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        adv(MODEL_POR + 10);
        chk("t5_no_ticks", 32'(tick), 32'd0);

        // Randomized traffic, including writes to the unimplemented channel index 3.
        for (int k = 0; k < 3000; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 3));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_en    = ($urandom_range(0, 3) != 0);
            sync      = ($urandom_range(0, 24) == 0);
            adv(1);
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;
        adv(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
